// File: rtl/crc_pkg.sv
// crc_pkg: shared state encoding, default sizes and bit order for the CRC front end
package crc_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CRC_WIDTH = 8;
  localparam int DEF_TIMEOUT = 64;
  localparam bit LSB_FIRST = 1'b1;
  typedef enum logic [2:0] {IDLE, INIT, SHIFT, WAIT_CRC, COLLECT, DONE} state_t;
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return $clog2(m) + 1;
  endfunction
endpackage

// File: rtl/crc_frame_sequencer_if.sv
// crc_frame_sequencer_if: byte handshake, serial CRC-stage link and collected result
interface crc_frame_sequencer_if
  import crc_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CRC_WIDTH = DEF_CRC_WIDTH
);
  logic [DATA_WIDTH-1:0] In_Data;
  logic In_Valid;
  logic In_Ready;
  logic Crc_Init;
  logic Data;
  logic Active;
  logic Crc_Bit;
  logic Crc_Valid;
  logic [CRC_WIDTH-1:0] Out_Crc;
  logic Out_Valid;
  logic Err;
  modport slave (
    input In_Data, In_Valid, Crc_Bit, Crc_Valid,
    output In_Ready, Crc_Init, Data, Active, Out_Crc, Out_Valid, Err
  );
  modport master (
    output In_Data, In_Valid, Crc_Bit, Crc_Valid,
    input In_Ready, Crc_Init, Data, Active, Out_Crc, Out_Valid, Err
  );
endinterface

// File: rtl/crc_bit_shifter.sv
// crc_bit_shifter: loadable shift register with serial in, parallel out and shift counter
module crc_bit_shifter
  import crc_pkg::*;
#(
  parameter int W = 8,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic [W-1:0] din,
  input  logic shift,
  input  logic sin,
  input  logic clr,
  output logic [W-1:0] q,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
      cnt <= '0;
    end else begin
      q <= load ? din : shift ? (LSB_FIRST ? {sin, q[W-1:1]} : {q[W-2:0], sin}) : q;
      cnt <= (load || clr) ? '0 : shift ? cnt + CNT_W'(1) : cnt;
    end
  end
endmodule

// File: rtl/crc_frame_sequencer.sv
// crc_frame_sequencer: byte handshake in, serial Data/Active to the CRC stage, Crc_Bit/Crc_Valid collected into Out_Crc
module crc_frame_sequencer
  import crc_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CRC_WIDTH = DEF_CRC_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic CLK,
  input logic RST,
  crc_frame_sequencer_if.slave bus
);
  localparam int CW = cnt_width(DATA_WIDTH, CRC_WIDTH, TIMEOUT);
  localparam logic [DATA_WIDTH-1:0] OUT_MASK = LSB_FIRST ? DATA_WIDTH'(1) : DATA_WIDTH'(1) << (DATA_WIDTH - 1);
  state_t state, next_state;
  logic in_ready, err, err_next;
  logic crc_init, active, data, out_valid;
  logic ser_load, ser_clr, col_shift, col_clr;
  logic [DATA_WIDTH-1:0] ser_q;
  logic [CRC_WIDTH-1:0] col_q;
  logic [CW-1:0] ser_cnt, col_cnt, wait_cnt;
  crc_bit_shifter #(.W(DATA_WIDTH), .CNT_W(CW)) u_ser (
    .clk(CLK),
    .rst(RST),
    .load(ser_load),
    .din(bus.In_Data),
    .shift(active),
    .sin(1'b0),
    .clr(ser_clr),
    .q(ser_q),
    .cnt(ser_cnt)
  );
  crc_bit_shifter #(.W(CRC_WIDTH), .CNT_W(CW)) u_col (
    .clk(CLK),
    .rst(RST),
    .load(1'b0),
    .din('0),
    .shift(col_shift),
    .sin(bus.Crc_Bit),
    .clr(col_clr),
    .q(col_q),
    .cnt(col_cnt)
  );
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      in_ready <= 1'b0;
      err <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state <= next_state;
      in_ready <= state == IDLE && next_state == IDLE;
      err <= err_next;
      wait_cnt <= (state == WAIT_CRC && next_state == WAIT_CRC) ? wait_cnt + CW'(1) : '0;
    end
  end
  always_comb begin
    next_state = state;
    err_next = 1'b0;
    case (state)
      IDLE: next_state = (bus.In_Valid && in_ready) ? INIT : IDLE;
      INIT: next_state = SHIFT;
      SHIFT: next_state = ser_cnt == CW'(DATA_WIDTH - 1) ? WAIT_CRC : SHIFT;
      WAIT_CRC: begin
        next_state = bus.Crc_Valid ? COLLECT : wait_cnt == CW'(TIMEOUT - 1) ? IDLE : WAIT_CRC;
        err_next = !bus.Crc_Valid && wait_cnt == CW'(TIMEOUT - 1);
      end
      COLLECT: begin
        next_state = !bus.Crc_Valid ? IDLE : col_cnt == CW'(CRC_WIDTH - 1) ? DONE : COLLECT;
        err_next = !bus.Crc_Valid;
      end
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end
  always_comb begin
    crc_init = state == INIT;
    active = state == SHIFT;
    data = active && |(ser_q & OUT_MASK);
    out_valid = state == DONE;
    ser_load = state == IDLE && bus.In_Valid && in_ready;
    ser_clr = state != SHIFT;
    col_shift = bus.Crc_Valid && (state == WAIT_CRC || state == COLLECT);
    col_clr = !(state == WAIT_CRC || state == COLLECT);
  end
  assign bus.In_Ready = in_ready;
  assign bus.Crc_Init = crc_init;
  assign bus.Data = data;
  assign bus.Active = active;
  assign bus.Out_Crc = col_q;
  assign bus.Out_Valid = out_valid;
  assign bus.Err = err;
endmodule

// File: doc/crc_frame_sequencer.md
Name: crc_frame_sequencer

Overview:
Byte-level front end for the serial CRC stage. It accepts parallel bytes over a valid/ready handshake and re-initialises the CRC stage for each byte. It then serialises the byte LSB-first on Data with Active high. Finally it collects the CRC stage's serial result, gated by the CRC stage's Valid, back into a parallel word. This lets the rest of the design talk to the CRC stage in bytes instead of bits.

Parameters:
DATA_WIDTH, 8, bits per input word shifted into the CRC stage
CRC_WIDTH, 8, bits of serial CRC result collected per word
TIMEOUT, 64, max cycles to wait in WAIT_CRC for Crc_Valid before flagging error

Ports:
CLK  in  1  clock, all logic on rising edge
RST  in  1  synchronous reset, active-high
In_Data  in  DATA_WIDTH  word to process
In_Valid  in  1  In_Data valid
In_Ready  out  1  sequencer can accept a word
Crc_Init  out  1  one-cycle active-high re-initialise request to the CRC stage
Data  out  1  serial data bit to the CRC stage
Active  out  1  Data qualifier to the CRC stage
Crc_Bit  in  1  serial CRC bit from the CRC stage
Crc_Valid  in  1  CRC stage result-valid
Out_Crc  out  CRC_WIDTH  collected CRC word, bit 0 = first bit received
Out_Valid  out  1  one-cycle pulse, Out_Crc valid
Err  out  1  one-cycle pulse: timeout or Crc_Valid dropped mid-collection

Behaviour:
- Reset values: In_Ready=0, Crc_Init=0, Data=0, Active=0, Out_Crc=0, Out_Valid=0, Err=0, state=IDLE. All counters and shift registers are cleared.
- RST is sampled every cycle. A reset mid-operation aborts immediately and does not produce Out_Valid or Err.
- FSM states: IDLE, INIT, SHIFT, WAIT_CRC, COLLECT, DONE.
- IDLE:
  - In_Ready=1 (registered output; it is 1 in the cycle after the state reaches IDLE).
  - In_Valid & In_Ready at an edge: latch In_Data into the shift register and go to INIT.
- INIT (1 cycle): Crc_Init=1, Active=0. Go to SHIFT.
- SHIFT (exactly DATA_WIDTH cycles):
  - Active=1, Data = shreg[0]; shift right each cycle, so bit 0 goes out first.
  - After DATA_WIDTH cycles go to WAIT_CRC. Active falls in that same edge.
- WAIT_CRC:
  - Active=0, Data=0; the wait counter increments each cycle.
  - Crc_Valid=1 at an edge: capture Crc_Bit into Out_Crc bit 0 (shift-in from MSB side so the first bit ends at bit 0), collected count=1, go to COLLECT.
  - Counter reaches TIMEOUT without Crc_Valid: Err pulse, go to IDLE.
- COLLECT:
  - On each edge with Crc_Valid=1, capture the next Crc_Bit.
  - When CRC_WIDTH bits are captured, go to DONE.
  - Crc_Valid=0 before CRC_WIDTH bits: Err pulse, Out_Crc is held (not flagged valid), go to IDLE.
- DONE (1 cycle): Out_Valid=1, Out_Crc stable. Go to IDLE.
  - Out_Crc holds its value until the next capture begins.
- Crc_Valid or Crc_Bit during IDLE, INIT or SHIFT is ignored.
- In_Valid outside IDLE is ignored. The upstream must hold the word until In_Ready.
- Latency from the accepting edge to the Out_Valid pulse is 1 + DATA_WIDTH + (cycles to Crc_Valid) + CRC_WIDTH. Minimum throughput is one word per that interval plus the IDLE cycle.
- Counters are sized to $clog2 of the maximum of DATA_WIDTH, CRC_WIDTH and TIMEOUT, plus 1. They never wrap; they are cleared on every state entry.

Decomposition:
- Shared package crc_pkg holds:
  - the state encoding (localparam enum of the six states);
  - default DATA_WIDTH, CRC_WIDTH and TIMEOUT;
  - the bit-order constant LSB_FIRST=1, shared with the CRC stage.
- One natural sub-module: crc_bit_shifter, a loadable shift register with serial out/in and bit counter.
  - Instantiated twice: once as the serialiser (parallel load, serial out) and once as the collector (serial in, parallel out).

Test Plan:
- Serialisation: word 0xB4 accepted -> Crc_Init high 1 cycle; then Active high exactly 8 cycles; Data sequence 0,0,1,0,1,1,0,1; In_Ready low throughout.
- Collection: stub CRC stage asserts Crc_Valid 8 cycles sending bits 1,0,1,0,0,1,0,1 -> Out_Crc=0xA5 with a single Out_Valid pulse; Err=0.
- Timeout: stub never asserts Crc_Valid, TIMEOUT=64 -> Err pulse exactly 64 cycles after entering WAIT_CRC; In_Ready=1 next cycle; Out_Valid never asserted.
- Valid dropout: Crc_Valid high 4 cycles then low -> Err pulse one cycle later; Out_Valid=0; next word 0x01 processes normally.
- Reset mid-SHIFT: RST=1 on 3rd Active cycle -> next cycle Active=0, Data=0, In_Ready=0. After RST falls: In_Ready=1, no Err and no Out_Valid pulse.
- Back-to-back: In_Valid held high with 0x00 then 0xFF -> second word accepted only after the first Out_Valid. Each word produces one Crc_Init, one 8-cycle Active window and one Out_Valid.
